// File: rtl/bcd_pkg.sv
// Shared decimal-arithmetic package.
// Provides the BCD digit type, decimal constants and the state encoding used by
// the serial BCD subtractor.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam int         BCD_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtract: computes a_i - b_i - borrow_i and folds a negative
// result back into the decimal range by adding the base.
// Illegal input digits (>9) go through the same arithmetic unchanged.
//
// Ports:
//   a_i       minuend digit
//   b_i       subtrahend digit
//   borrow_i  borrow from the lower digit
//   digit_o   result digit
//   borrow_o  borrow into the next digit
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       borrow_i,
  output bcd_digit_t digit_o,
  output logic       borrow_o
);

  // Range is -16..15 for any 4-bit inputs, so 6 signed bits never overflow.
  logic signed [5:0] t;
  logic signed [5:0] t_adj;

  always_comb begin
    t     = $signed({2'b00, a_i}) - $signed({2'b00, b_i}) - $signed({5'b0_0000, borrow_i});
    t_adj = t + 6'(BCD_BASE);
    if (t < 6'sd0) begin
      digit_o  = t_adj[3:0];
      borrow_o = 1'b1;
    end else begin
      digit_o  = t[3:0];
      borrow_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Multi-digit packed-BCD serial subtractor: A - B - bin, one digit per clock,
// least-significant digit first, with a ripple borrow held between cycles.
// Operands arrive on a valid/ready handshake; the ten's-complement difference
// and borrow-out leave on a second valid/ready handshake.
//
// Optional feature macro: BCD_SUB_DIGIT_CHECK_EN
//   defined   - err_o flags any operand digit > 9, latched at accept.
//   undefined - err_o tied to 0.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   in_valid_i   operands present
//   in_ready_o   block can accept operands (IDLE only)
//   a_i, b_i     packed-BCD minuend / subtrahend, digit 0 in [3:0]
//   bin_i        borrow-in
//   out_valid_o  result present (DONE)
//   out_ready_i  consumer accepts result
//   diff_o       packed-BCD difference
//   bout_o       borrow-out (1 => A < B + bin)
//   err_o        illegal input digit flag
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  bin_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*DIGITS-1:0]   diff_o,
  output logic                  bout_o,
  output logic                  err_o
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  sub_state_t      state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;
  logic            bout_q, bout_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  bcd_digit_t dig_a, dig_b, dig_res;
  logic       dig_bout;
  logic       accept;

  // Single digit slice, steered by the digit counter.
  assign dig_a = a_q[{cnt_q, 2'b00} +: 4];
  assign dig_b = b_q[{cnt_q, 2'b00} +: 4];

  bcd_digit_sub u_digit_sub (
    .a_i      (dig_a),
    .b_i      (dig_b),
    .borrow_i (borrow_q),
    .digit_o  (dig_res),
    .borrow_o (dig_bout)
  );

  // State is already IDLE during reset; gate on rst_i so the block never
  // advertises readiness while held in reset.
  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == DONE);
  assign diff_o      = diff_q;
  assign bout_o      = bout_q;
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = bin_i;
          diff_d   = '0;
          bout_d   = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        diff_d[{cnt_q, 2'b00} +: 4] = dig_res;
        borrow_d                    = dig_bout;
        if (cnt_q == LastCnt) begin
          bout_d  = dig_bout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BCD_SUB_DIGIT_CHECK_EN
  logic err_q, err_d;

  function automatic logic has_illegal(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
    return bad;
  endfunction

  always_comb begin
    err_d = err_q;
    if (accept) err_d = has_illegal(a_i) || has_illegal(b_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;

  localparam int unsigned D = 4;

`ifdef BCD_SUB_DIGIT_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] diff;
  logic        bout;
  logic        err;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .bin_i       (bin),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .diff_o      (diff),
    .bout_o      (bout),
    .err_o       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r = '0;
    int          x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Integer reference model; valid for legal BCD operands only.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    exp_t e;
    int   r = bcd2int(av) - bcd2int(bv) - int'(bi);
    e.bout = (r < 0);
    if (r < 0) r += 10000;
    e.diff = int2bcd(r);
    e.err  = 1'b0;
    return e;
  endfunction

  // Drive operands at #1 after an edge, hold until accepted, push expectation.
  task automatic send_exp(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          input exp_t e);
    logic ok;
    int   cyc = 0;
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    forever begin
      ok = in_ready;
      @(posedge clk);
      if (ok) break;
      cyc++;
      if (cyc > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic bi);
    send_exp(av, bv, bi, model(av, bv, bi));
  endtask

  // Wait for the result (called right after the accept edge), compare it,
  // optionally stall for 'hold' cycles, then complete the handshake.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    int   cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(D));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_diff"}, 32'(diff), 32'(e.diff));
    check({tag, "_bout"}, 32'(bout), 32'(e.bout));
    check({tag, "_err"}, 32'(err), 32'(e.err));
    for (int i = 0; i < hold; i++) begin
      a = 16'h7777; b = 16'h1111; in_valid = 1'b1;
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_diff"}, 32'(diff), 32'(e.diff));
      check({tag, "_hold_bout"}, 32'(bout), 32'(e.bout));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(in_ready), 32'd1);
  endtask

  exp_t e_tmp;

  initial begin
    // Reset state.
    #12;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    send(16'h5432, 16'h1234, 1'b0);
    collect("t5432", 0);
    e_tmp.diff = 16'h9998; e_tmp.bout = 1'b1; e_tmp.err = 1'b0;
    send_exp(16'h0003, 16'h0005, 1'b0, e_tmp);
    collect("t0003", 3);  // back-pressure with stray in_valid
    e_tmp.diff = 16'h0998; e_tmp.bout = 1'b0; e_tmp.err = 1'b0;
    send_exp(16'h1000, 16'h0001, 1'b1, e_tmp);
    collect("t1000", 0);

    // Reset after two digits of 9999-0001.
    send(16'h9999, 16'h0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    check("abort_valid2", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    e_tmp.diff = 16'h0009; e_tmp.bout = 1'b0; e_tmp.err = 1'b0;
    send_exp(16'h0010, 16'h0001, 1'b0, e_tmp);
    collect("t0010", 0);

    // Illegal digit: arithmetic passes it through; err depends on build.
    e_tmp.diff = 16'h00A0; e_tmp.bout = 1'b0; e_tmp.err = ErrExp;
    send_exp(16'h00A0, 16'h0000, 1'b0, e_tmp);
    collect("t00A0", 0);
    // Next legal accept must clear err.
    send(16'h0000, 16'h0000, 1'b1);
    collect("t0000", 0);

    // A few random legal operands against the integer model.
    for (int k = 0; k < 4; k++) begin
      send(int2bcd(int'($urandom_range(0, 9999))), int2bcd(int'($urandom_range(0, 9999))),
           1'($urandom_range(0, 1)));
      collect("rand", 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
